rv32im_writeback: RTL and testbench

- Writer/initiator side of the rv32im register file.
- Arbitrates results from three producers (load unit, mul/div unit, ALU) onto the register file's single write port.
- Keeps a per-register busy scoreboard so decode can detect RAW/WAW hazards.
- Gates the register file read strobe. The register file has no write-through, so a read issued in the same cycle as a write to the same register returns stale data; this block must prevent that.

---
 rtl/rv32im_writeback_pkg.sv | 13 +
 rtl/rv32im_scoreboard.sv | 49 ++++
 rtl/rv32im_writeback.sv | 140 ++++++++++++++
 tb/tb_rv32im_writeback.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_writeback_pkg.sv
// Shared parameters and producer-source encoding for the rv32im writeback slice.
package rv32im_writeback_pkg;

    localparam int unsigned DEF_XLEN     = 32;
    localparam int unsigned DEF_REG_BITS = 5;

    typedef enum logic [1:0] {
        SRC_MEM = 2'd0,
        SRC_MD  = 2'd1,
        SRC_ALU = 2'd2
    } src_e;

endpackage

// File: rtl/rv32im_scoreboard.sv
// Per-register busy bits: set when decode claims a destination, cleared when
// its result is accepted. Register 0 is never marked busy.
module rv32im_scoreboard
    import rv32im_writeback_pkg::*;
#(
    parameter int unsigned REG_BITS = DEF_REG_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     set_i,
    input  logic [REG_BITS-1:0]      set_rd_i,
    input  logic                     clr_i,
    input  logic [REG_BITS-1:0]      clr_rd_i,
    input  logic [REG_BITS-1:0]      rd_a_i,
    output logic                     busy_a_o,
    input  logic [REG_BITS-1:0]      rd_b_i,
    output logic                     busy_b_o,
    output logic [2**REG_BITS-1:0]   busy_o
);

    localparam int unsigned NREGS = 2**REG_BITS;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_a_o = busy_q[rd_a_i];
    assign busy_b_o = busy_q[rd_b_i];
    assign busy_o   = busy_q;

endmodule

// File: rtl/rv32im_writeback.sv
// Writeback arbiter (mem > md > alu) with a one-stage register file write port,
// busy scoreboard and hazard-gated read strobe.
module rv32im_writeback
    import rv32im_writeback_pkg::*;
#(
    parameter int unsigned XLEN     = DEF_XLEN,
    parameter int unsigned REG_BITS = DEF_REG_BITS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    input  logic [REG_BITS-1:0] issue_rd_i,
    output logic                issue_ready_o,
    input  logic [REG_BITS-1:0] rs1_addr_i,
    input  logic [REG_BITS-1:0] rs2_addr_i,
    input  logic                read_req_i,
    output logic                hazard_o,
    output logic                rf_read_o,
    input  logic                mem_valid_i,
    input  logic [REG_BITS-1:0] mem_rd_i,
    input  logic [XLEN-1:0]     mem_data_i,
    output logic                mem_ready_o,
    input  logic                md_valid_i,
    input  logic [REG_BITS-1:0] md_rd_i,
    input  logic [XLEN-1:0]     md_data_i,
    output logic                md_ready_o,
    input  logic                alu_valid_i,
    input  logic [REG_BITS-1:0] alu_rd_i,
    input  logic [XLEN-1:0]     alu_data_i,
    output logic                alu_ready_o,
    output logic                rf_write_o,
    output logic [REG_BITS-1:0] rf_rd_addr_o,
    output logic [XLEN-1:0]     rf_data_o,
    output logic                err_o
);

    logic [2**REG_BITS-1:0] busy;
    logic                   busy_rs1;
    logic                   busy_rs2;
    logic                   issue_accept;
    logic                   accept;
    src_e                   src;
    logic [REG_BITS-1:0]    sel_rd;
    logic [XLEN-1:0]        sel_data;

    logic                   rf_write_q, rf_write_d;
    logic [REG_BITS-1:0]    rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]        rf_data_q, rf_data_d;
    logic                   err_q, err_d;

    assign issue_ready_o = !busy[issue_rd_i] || (issue_rd_i == '0);
    assign issue_accept  = issue_valid_i && issue_ready_o;

    assign mem_ready_o = 1'b1;
    assign md_ready_o  = !mem_valid_i;
    assign alu_ready_o = !mem_valid_i && !md_valid_i;

    always_comb begin
        accept = 1'b1;
        src    = SRC_ALU;
        if (mem_valid_i) begin
            src = SRC_MEM;
        end else if (md_valid_i) begin
            src = SRC_MD;
        end else if (!alu_valid_i) begin
            accept = 1'b0;
        end
        sel_rd   = alu_rd_i;
        sel_data = alu_data_i;
        case (src)
            SRC_MEM: begin
                sel_rd   = mem_rd_i;
                sel_data = mem_data_i;
            end
            SRC_MD: begin
                sel_rd   = md_rd_i;
                sel_data = md_data_i;
            end
            default: begin
                sel_rd   = alu_rd_i;
                sel_data = alu_data_i;
            end
        endcase
    end

    rv32im_scoreboard #(
        .REG_BITS (REG_BITS)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .set_i    (issue_accept),
        .set_rd_i (issue_rd_i),
        .clr_i    (accept),
        .clr_rd_i (sel_rd),
        .rd_a_i   (rs1_addr_i),
        .busy_a_o (busy_rs1),
        .rd_b_i   (rs2_addr_i),
        .busy_b_o (busy_rs2),
        .busy_o   (busy)
    );

    // Address/data hold when idle; only the strobe and error pulse drop.
    always_comb begin
        rf_write_d = accept && (sel_rd != '0);
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        err_d      = accept && (sel_rd != '0) && !busy[sel_rd];
        if (accept) begin
            rf_addr_d = sel_rd;
            rf_data_d = sel_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
            err_q      <= err_d;
        end
    end

    assign rf_write_o   = rf_write_q;
    assign rf_rd_addr_o = rf_addr_q;
    assign rf_data_o    = rf_data_q;
    assign err_o        = err_q;

    // No write-through in the register file: a write in flight counts as a hazard.
    assign hazard_o = ((rs1_addr_i != '0) &&
                       (busy_rs1 || (rf_write_q && (rf_addr_q == rs1_addr_i)))) ||
                      ((rs2_addr_i != '0) &&
                       (busy_rs2 || (rf_write_q && (rf_addr_q == rs2_addr_i))));
    assign rf_read_o = read_req_i && !hazard_o;

endmodule

// File: tb/tb_rv32im_writeback.sv
// Directed-vector bench for rv32im_writeback with hand-computed expectations.
module tb_rv32im_writeback;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        issue_ready_o;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        read_req_i;
    logic        hazard_o;
    logic        rf_read_o;
    logic        mem_valid_i;
    logic [4:0]  mem_rd_i;
    logic [31:0] mem_data_i;
    logic        mem_ready_o;
    logic        md_valid_i;
    logic [4:0]  md_rd_i;
    logic [31:0] md_data_i;
    logic        md_ready_o;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        alu_ready_o;
    logic        rf_write_o;
    logic [4:0]  rf_rd_addr_o;
    logic [31:0] rf_data_o;
    logic        err_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk_i = ~clk_i;

    rv32im_writeback #(
        .XLEN     (32),
        .REG_BITS (5)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .issue_ready_o (issue_ready_o),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .read_req_i    (read_req_i),
        .hazard_o      (hazard_o),
        .rf_read_o     (rf_read_o),
        .mem_valid_i   (mem_valid_i),
        .mem_rd_i      (mem_rd_i),
        .mem_data_i    (mem_data_i),
        .mem_ready_o   (mem_ready_o),
        .md_valid_i    (md_valid_i),
        .md_rd_i       (md_rd_i),
        .md_data_i     (md_data_i),
        .md_ready_o    (md_ready_o),
        .alu_valid_i   (alu_valid_i),
        .alu_rd_i      (alu_rd_i),
        .alu_data_i    (alu_data_i),
        .alu_ready_o   (alu_ready_o),
        .rf_write_o    (rf_write_o),
        .rf_rd_addr_o  (rf_rd_addr_o),
        .rf_data_o     (rf_data_o),
        .err_o         (err_o)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid_i = 1'b1;
        issue_rd_i    = rd;
        #1;
        check_vec($sformatf("issue_ready rd%0d", rd), {31'd0, issue_ready_o}, 32'd1);
        tick();
        issue_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        issue_valid_i = 1'b0; issue_rd_i = '0;
        rs1_addr_i = '0; rs2_addr_i = '0; read_req_i = 1'b0;
        mem_valid_i = 1'b0; mem_rd_i = '0; mem_data_i = '0;
        md_valid_i = 1'b0; md_rd_i = '0; md_data_i = '0;
        alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
        #12;
        check_vec("reset rf_write", {31'd0, rf_write_o}, 32'd0);
        check_vec("reset rf_addr", {27'd0, rf_rd_addr_o}, 32'd0);
        check_vec("reset rf_data", rf_data_o, 32'd0);
        check_vec("reset err", {31'd0, err_o}, 32'd0);
        check_vec("reset hazard", {31'd0, hazard_o}, 32'd0);
        rst_ni = 1'b1;
        tick();
        check_vec("post-release rf_write", {31'd0, rf_write_o}, 32'd0);

        // 1: RAW hazard on rd5 through writeback
        issue(5'd5);
        rs1_addr_i = 5'd5; read_req_i = 1'b1;
        #1;
        check_vec("t1 hazard busy", {31'd0, hazard_o}, 32'd1);
        check_vec("t1 rf_read busy", {31'd0, rf_read_o}, 32'd0);
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        #1;
        check_vec("t1 alu_ready", {31'd0, alu_ready_o}, 32'd1);
        tick();
        alu_valid_i = 1'b0;
        check_vec("t1 rf_write", {31'd0, rf_write_o}, 32'd1);
        check_vec("t1 rf_addr", {27'd0, rf_rd_addr_o}, 32'd5);
        check_vec("t1 rf_data", rf_data_o, 32'hDEADBEEF);
        check_vec("t1 err", {31'd0, err_o}, 32'd0);
        check_vec("t1 hazard inflight", {31'd0, hazard_o}, 32'd1);
        check_vec("t1 rf_read inflight", {31'd0, rf_read_o}, 32'd0);
        tick();
        check_vec("t1 hazard clear", {31'd0, hazard_o}, 32'd0);
        check_vec("t1 rf_read", {31'd0, rf_read_o}, 32'd1);
        check_vec("t1 addr hold", {27'd0, rf_rd_addr_o}, 32'd5);
        check_vec("t1 data hold", rf_data_o, 32'hDEADBEEF);
        rs1_addr_i = '0; read_req_i = 1'b0;

        // 2: three producers at once
        issue(5'd3); issue(5'd4); issue(5'd6);
        mem_valid_i = 1'b1; mem_rd_i = 5'd3; mem_data_i = 32'hA0A0A0A0;
        md_valid_i  = 1'b1; md_rd_i  = 5'd4; md_data_i  = 32'hB1B1B1B1;
        alu_valid_i = 1'b1; alu_rd_i = 5'd6; alu_data_i = 32'hC2C2C2C2;
        #1;
        check_vec("t2 mem_ready", {31'd0, mem_ready_o}, 32'd1);
        check_vec("t2 md_ready c0", {31'd0, md_ready_o}, 32'd0);
        check_vec("t2 alu_ready c0", {31'd0, alu_ready_o}, 32'd0);
        tick();
        mem_valid_i = 1'b0;
        #1;
        check_vec("t2 w0 addr", {27'd0, rf_rd_addr_o}, 32'd3);
        check_vec("t2 w0 data", rf_data_o, 32'hA0A0A0A0);
        check_vec("t2 md_ready c1", {31'd0, md_ready_o}, 32'd1);
        check_vec("t2 alu_ready c1", {31'd0, alu_ready_o}, 32'd0);
        tick();
        md_valid_i = 1'b0;
        #1;
        check_vec("t2 w1 addr", {27'd0, rf_rd_addr_o}, 32'd4);
        check_vec("t2 w1 data", rf_data_o, 32'hB1B1B1B1);
        check_vec("t2 alu_ready c2", {31'd0, alu_ready_o}, 32'd1);
        tick();
        alu_valid_i = 1'b0;
        check_vec("t2 w2 write", {31'd0, rf_write_o}, 32'd1);
        check_vec("t2 w2 addr", {27'd0, rf_rd_addr_o}, 32'd6);
        check_vec("t2 w2 data", rf_data_o, 32'hC2C2C2C2);
        tick();
        check_vec("t2 idle write", {31'd0, rf_write_o}, 32'd0);

        // 3: WAW stall on rd7
        issue(5'd7);
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        #1;
        check_vec("t3 waw stall", {31'd0, issue_ready_o}, 32'd0);
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h00000077;
        #1;
        check_vec("t3 stall during accept", {31'd0, issue_ready_o}, 32'd0);
        tick();
        alu_valid_i = 1'b0;
        issue_valid_i = 1'b0;
        #1;
        check_vec("t3 ready after", {31'd0, issue_ready_o}, 32'd1);
        check_vec("t3 write rd7", {27'd0, rf_rd_addr_o}, 32'd7);
        check_vec("t3 err", {31'd0, err_o}, 32'd0);
        tick();

        // 4: result to x0
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h12345678;
        rs1_addr_i = 5'd0; read_req_i = 1'b1;
        #1;
        check_vec("t4 alu_ready", {31'd0, alu_ready_o}, 32'd1);
        tick();
        alu_valid_i = 1'b0;
        check_vec("t4 rf_write", {31'd0, rf_write_o}, 32'd0);
        check_vec("t4 err", {31'd0, err_o}, 32'd0);
        check_vec("t4 hazard", {31'd0, hazard_o}, 32'd0);
        check_vec("t4 rf_read", {31'd0, rf_read_o}, 32'd1);
        read_req_i = 1'b0;
        tick();

        // 5: result to a register that is not busy
        alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = 32'h00000001;
        tick();
        alu_valid_i = 1'b0;
        check_vec("t5 rf_write", {31'd0, rf_write_o}, 32'd1);
        check_vec("t5 err", {31'd0, err_o}, 32'd1);
        check_vec("t5 addr", {27'd0, rf_rd_addr_o}, 32'd9);
        check_vec("t5 data", rf_data_o, 32'h00000001);
        tick();
        check_vec("t5 err pulse end", {31'd0, err_o}, 32'd0);
        check_vec("t5 write end", {31'd0, rf_write_o}, 32'd0);

        // 6: reset with a write in flight and a register still busy
        issue(5'd11);
        issue(5'd10);
        alu_valid_i = 1'b1; alu_rd_i = 5'd10; alu_data_i = 32'h0000AAAA;
        tick();
        alu_valid_i = 1'b0;
        check_vec("t6 inflight write", {31'd0, rf_write_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check_vec("t6 reset rf_write", {31'd0, rf_write_o}, 32'd0);
        check_vec("t6 reset addr", {27'd0, rf_rd_addr_o}, 32'd0);
        check_vec("t6 reset data", rf_data_o, 32'd0);
        for (int r = 0; r < 32; r++) begin
            issue_rd_i = 5'(r);
            #1;
            check_vec($sformatf("t6 ready rd%0d", r), {31'd0, issue_ready_o}, 32'd1);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check_vec("t6 no write after release", {31'd0, rf_write_o}, 32'd0);
        issue_rd_i = 5'd11;
        #1;
        check_vec("t6 rd11 free", {31'd0, issue_ready_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
